// File: rtl/bp_update_sched_pkg.sv
// Package bp_defs: shared definitions for the branch-predictor update scheduler.
//   - bp_st_e      : scheduler FSM state encoding (INIT / RUN / DRAIN)
//   - BP_UPD_W     : width of one packed update record (67 bits)
//   - bp_upd_t     : packed update record {addr, target, jumpinst, jump, predfail}
//   - BP_PHT_INIT  : value the predictor writes into a PHT entry while init_we=1
package bp_defs;

  typedef enum logic [1:0] {
    BP_ST_INIT  = 2'd0,
    BP_ST_RUN   = 2'd1,
    BP_ST_DRAIN = 2'd2
  } bp_st_e;

  localparam int BP_UPD_W = 67;

  localparam logic [1:0] BP_PHT_INIT = 2'b11;

  // predfail sits in bit 0 so the packed record reads {addr, target, jumpinst, jump, predfail}
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] target;
    logic        jumpinst;
    logic        jump;
    logic        predfail;
  } bp_upd_t;

endpackage

// File: rtl/bp_update_sched_fifo.sv
// bp_upd_fifo: DEPTH x W synchronous FIFO holding resolved-branch updates.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (pointers only)
//   push_i, din_i     write din_i when push_i=1 (caller guarantees !full_o)
//   pop_i, dout_o     dout_o shows the head; pop_i=1 advances it (caller guarantees !empty_o)
//   full_o, empty_o   occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
module bp_upd_fifo
  import bp_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = BP_UPD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Storage needs no reset: a slot is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_ONE;
      if (pop_i)  rd_q <= rd_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: sequences the branch predictor's single update port and
// its table initialisation walk.
//   - Commit-stage updates (in_*) are queued in a small FIFO and issued one per
//     cycle as a registered strobe plus payload on bp_upd_*.
//   - After reset, or on init_req, every table index is walked (init_we/init_idx).
//   - predict_allow gates prediction until the tables are valid.
// Handshake: an update transfers on a rising edge where in_valid && in_ready;
// in_* are only sampled then, and the producer holds in_valid until accepted.
// Ports: clk, reset (async, active high); in_valid/in_ready/in_addr/in_jumpinst/
// in_jump/in_predfail/in_target; init_req; bp_upd_en + payload; init_we/init_idx;
// predict_allow; busy; state_dbg (current FSM state, bp_st_e encoding).
// Option: define BP_UPD_STATS_EN to add saturating counters stat_upd/stat_mispred.
module bp_update_sched
  import bp_defs::*;
#(
  parameter int DEPTH     = 4,
  parameter int TBL_IDX_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_addr,
  input  logic                 in_jumpinst,
  input  logic                 in_jump,
  input  logic                 in_predfail,
  input  logic [31:0]          in_target,
  input  logic                 init_req,
  output logic                 bp_upd_en,
  output logic [31:0]          bp_upd_addr,
  output logic                 bp_upd_jumpinst,
  output logic                 bp_upd_jump,
  output logic                 bp_upd_predfail,
  output logic [31:0]          bp_upd_target,
  output logic                 init_we,
  output logic [TBL_IDX_W-1:0] init_idx,
  output logic                 predict_allow,
  output logic                 busy,
`ifdef BP_UPD_STATS_EN
  output logic [31:0]          stat_upd,
  output logic [31:0]          stat_mispred,
`endif
  output logic [1:0]           state_dbg
);

  localparam logic [TBL_IDX_W-1:0] IDX_ONE = {{(TBL_IDX_W-1){1'b0}}, 1'b1};

  bp_st_e               state_q, state_d;
  logic [TBL_IDX_W-1:0] init_idx_q;
  logic                 upd_en_q;
  bp_upd_t              upd_q;
  logic                 predict_allow_q;

  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  bp_upd_t              in_upd, head_upd;
  logic [BP_UPD_W-1:0]  fifo_dout;

  assign in_upd = '{addr: in_addr, target: in_target, jumpinst: in_jumpinst,
                    jump: in_jump, predfail: in_predfail};
  assign head_upd = bp_upd_t'(fifo_dout);

  bp_upd_fifo #(.DEPTH(DEPTH), .W(BP_UPD_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (in_upd),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    init_we  = 1'b0;
    case (state_q)
      BP_ST_INIT: begin
        init_we = 1'b1;
        if (init_idx_q == '1) state_d = BP_ST_RUN;
      end
      BP_ST_RUN: begin
        // Full blocks acceptance even if a pop happens this cycle.
        in_ready = !fifo_full;
        if (init_req) state_d = BP_ST_DRAIN;
      end
      BP_ST_DRAIN: begin
        // An empty FIFO cannot issue, so this is the first idle drain cycle.
        if (fifo_empty) state_d = BP_ST_INIT;
      end
      default: state_d = BP_ST_INIT;
    endcase
  end

  assign push = in_valid && in_ready;
  assign pop  = (state_q != BP_ST_INIT) && !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= BP_ST_INIT;
      init_idx_q      <= '0;
      upd_en_q        <= 1'b0;
      upd_q           <= '0;
      predict_allow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      // Index advances only while walking; wraps to 0 as RUN is entered and
      // is held at 0 outside INIT so a new walk always starts at entry 0.
      init_idx_q      <= (state_q == BP_ST_INIT) ? init_idx_q + IDX_ONE : '0;
      upd_en_q        <= pop;
      upd_q           <= pop ? head_upd : '0;
      predict_allow_q <= (state_d != BP_ST_INIT);
    end
  end

`ifdef BP_UPD_STATS_EN
  logic [31:0] stat_upd_q, stat_mispred_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_upd_q     <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (upd_en_q && (stat_upd_q != '1)) stat_upd_q <= stat_upd_q + 32'd1;
      if (upd_en_q && upd_q.predfail && (stat_mispred_q != '1))
        stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_upd     = stat_upd_q;
  assign stat_mispred = stat_mispred_q;
`endif

  assign bp_upd_en       = upd_en_q;
  assign bp_upd_addr     = upd_q.addr;
  assign bp_upd_target   = upd_q.target;
  assign bp_upd_jumpinst = upd_q.jumpinst;
  assign bp_upd_jump     = upd_q.jump;
  assign bp_upd_predfail = upd_q.predfail;
  assign init_idx        = init_idx_q;
  assign predict_allow   = predict_allow_q;
  assign busy            = (state_q != BP_ST_RUN) || !fifo_empty;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Testbench for bp_update_sched (DEPTH=4, TBL_IDX_W=4).
// A queue-based model tracks the scheduler's phase, walk position and pending
// updates; a negedge process compares every DUT output against it each cycle.
// Directed sequences add hand-computed literal expectations.
module tb_bp_update_sched;

  localparam int DEPTH = 4;
  localparam int IW    = 4;
  localparam int NIDX  = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [31:0]   in_addr, in_target;
  logic          in_jumpinst, in_jump, in_predfail;
  logic          init_req;
  logic          bp_upd_en;
  logic [31:0]   bp_upd_addr, bp_upd_target;
  logic          bp_upd_jumpinst, bp_upd_jump, bp_upd_predfail;
  logic          init_we;
  logic [IW-1:0] init_idx;
  logic          predict_allow, busy;
  logic [1:0]    state_dbg;
`ifdef BP_UPD_STATS_EN
  logic [31:0]   stat_upd, stat_mispred;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bp_update_sched #(.DEPTH(DEPTH), .TBL_IDX_W(IW)) dut (
    .clk             (clk),
    .reset           (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_addr         (in_addr),
    .in_jumpinst     (in_jumpinst),
    .in_jump         (in_jump),
    .in_predfail     (in_predfail),
    .in_target       (in_target),
    .init_req        (init_req),
    .bp_upd_en       (bp_upd_en),
    .bp_upd_addr     (bp_upd_addr),
    .bp_upd_jumpinst (bp_upd_jumpinst),
    .bp_upd_jump     (bp_upd_jump),
    .bp_upd_predfail (bp_upd_predfail),
    .bp_upd_target   (bp_upd_target),
    .init_we         (init_we),
    .init_idx        (init_idx),
    .predict_allow   (predict_allow),
    .busy            (busy),
`ifdef BP_UPD_STATS_EN
    .stat_upd        (stat_upd),
    .stat_mispred    (stat_mispred),
`endif
    .state_dbg       (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 = walking tables, 1 = running, 2 = draining
  int          m_mode;
  int          m_walk;
  logic [66:0] exp_q[$];
  logic        m_en;
  logic [66:0] m_pl;
  logic        m_pa;
  logic [31:0] m_su, m_sm;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_walk = 0; exp_q.delete();
      m_en = 1'b0; m_pl = '0; m_pa = 1'b0; m_su = '0; m_sm = '0;
    end else begin
      int   sz0;
      logic acc, issue;
      sz0   = exp_q.size();
      acc   = in_valid && (m_mode == 1) && (sz0 < DEPTH);
      issue = (m_mode != 0) && (sz0 > 0);
      if (m_en) begin
        if (m_su != 32'hFFFF_FFFF) m_su = m_su + 1;
        if (m_pl[0] && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
      end
      if (issue) begin m_pl = exp_q.pop_front(); m_en = 1'b1; end
      else m_en = 1'b0;
      if (acc) exp_q.push_back({in_addr, in_target, in_jumpinst, in_jump, in_predfail});
      case (m_mode)
        0: if (m_walk == NIDX - 1) begin m_mode = 1; m_walk = 0; end
           else m_walk = m_walk + 1;
        1: if (init_req) m_mode = 2;
        default: if (sz0 == 0) m_mode = 0;
      endcase
      m_pa = (m_mode != 0);
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, (m_mode == 1) && (exp_q.size() < DEPTH));
      chk("init_we", init_we, m_mode == 0);
      chk("init_idx", init_idx, (m_mode == 0) ? m_walk : 0);
      chk("predict_allow", predict_allow, m_pa);
      chk("busy", busy, (m_mode != 1) || (exp_q.size() != 0));
      chk("state_dbg", state_dbg, m_mode);
      chk("bp_upd_en", bp_upd_en, m_en);
      if (m_en)
        chk("bp_upd_payload",
            {bp_upd_addr, bp_upd_target, bp_upd_jumpinst, bp_upd_jump, bp_upd_predfail}, m_pl);
`ifdef BP_UPD_STATS_EN
      chk("stat_upd", stat_upd, m_su);
      chk("stat_mispred", stat_mispred, m_sm);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 0; in_addr = '0; in_target = '0;
    in_jumpinst = 0; in_jump = 0; in_predfail = 0; init_req = 0;
  endtask

  task automatic drive_upd(input logic [31:0] a, input logic [31:0] t,
                           input logic ji, input logic j, input logic pf);
    in_valid = 1; in_addr = a; in_target = t;
    in_jumpinst = ji; in_jump = j; in_predfail = pf;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_init_we"}, init_we, 1);
    chk({tag, "_init_idx"}, init_idx, 0);
    chk({tag, "_upd_en"}, bp_upd_en, 0);
    chk({tag, "_payload"},
        {bp_upd_addr, bp_upd_target, bp_upd_jumpinst, bp_upd_jump, bp_upd_predfail}, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_predict_allow"}, predict_allow, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (!(predict_allow && in_ready) && n < 200) begin
      @(negedge clk); n++;
    end
    chk({tag, "_reach_run"}, (n < 200), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          cnt;
    int          first_i, last_i;
    logic [7:0]  got[$];
    idle_inputs();
    rst = 1;
    #1 check_reset_vals("por");
    repeat (2) @(negedge clk);
    rst = 0;

    // Table walk: 16 cycles of init_we, indices 0..15, then RUN.
    cnt = 0;
    while (init_we && cnt < 100) begin
      chk("walk_idx", init_idx, cnt[IW-1:0]);
      cnt++;
      @(negedge clk);
    end
    chk("walk_len", cnt, NIDX);
    chk("pa_after_walk", predict_allow, 1);
    chk("ready_after_walk", in_ready, 1);

    // Single update: en one cycle after the accepting edge, then idle.
    drive_upd(32'h100, 32'h200, 1, 1, 0);
    @(negedge clk); idle_inputs();
    chk("single_lat_en0", bp_upd_en, 0);
    @(negedge clk);
    chk("single_en", bp_upd_en, 1);
    chk("single_addr", bp_upd_addr, 32'h100);
    chk("single_target", bp_upd_target, 32'h200);
    chk("single_jump", bp_upd_jump, 1);
    @(negedge clk);
    chk("single_en_drop", bp_upd_en, 0);

    // Four back-to-back: issued in order on consecutive cycles.
    first_i = -1; last_i = -1; got.delete();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive_upd((i + 1) * 16, 32'h1000 + i, 1, i[0], 0);
      else idle_inputs();
      @(negedge clk);
      if (bp_upd_en) begin
        got.push_back(bp_upd_addr[7:0]);
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    chk("b2b_count", got.size(), 4);
    chk("b2b_span", last_i - first_i, 3);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("b2b_order", got[i], (i + 1) * 16);

    // Drain: three pushes with init_req on the last, producer keeps in_valid high.
    for (int i = 0; i < 3; i++) begin
      drive_upd(32'h300 + i, 32'h400, 1, 0, 1);
      init_req = (i == 2);
      @(negedge clk);
    end
    init_req = 0;
    drive_upd(32'hBAD, 32'hBAD, 1, 1, 1);
    cnt = 0;
    while (!init_we && cnt < 50) begin
      chk("drain_no_ready", in_ready, 0);
      @(negedge clk); cnt++;
    end
    chk("drain_to_init", init_we, 1);
    chk("drain_init_idx0", init_idx, 0);
    chk("drain_pa0", predict_allow, 0);
    chk("init_no_ready", in_ready, 0);

    // Reset mid-walk at index 7.
    cnt = 0;
    while (init_idx != 7 && cnt < 50) begin @(negedge clk); cnt++; end
    chk("reach_idx7", init_idx, 7);
    idle_inputs();
    #2 rst = 1;
    #1 check_reset_vals("rst_mid_init");
    @(negedge clk); rst = 0;
    chk("walk_restart", init_idx, 0);

    // Reset mid-RUN with updates in flight.
    wait_run("pre_rst_run");
    drive_upd(32'h500, 32'h600, 1, 1, 0); @(negedge clk);
    drive_upd(32'h504, 32'h604, 1, 0, 1); @(negedge clk);
    idle_inputs();
    #2 rst = 1;
    #1 check_reset_vals("rst_mid_run");
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("no_stale_en", bp_upd_en, 0);

    // Randomized traffic with occasional re-initialisation.
    wait_run("pre_random");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 70)
        drive_upd({24'h0, 4'h0, 4'($urandom_range(0, 7))} << 2, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else in_valid = 0;
      init_req = ($urandom_range(0, 99) < 3);
      @(negedge clk);
    end
    idle_inputs();
    repeat (30) @(negedge clk);

`ifdef BP_UPD_STATS_EN
    rst = 1; @(negedge clk); rst = 0;
    wait_run("stats_run");
    for (int i = 0; i < 5; i++) begin
      drive_upd(32'h700 + i, 32'h800, 1, 1, (i == 0) || (i == 2));
      @(negedge clk);
    end
    idle_inputs();
    repeat (4) @(negedge clk);
    chk("stats_upd5", stat_upd, 5);
    chk("stats_mis2", stat_mispred, 2);
    init_req = 1; @(negedge clk); init_req = 0;
    wait_run("stats_reinit");
    chk("stats_upd_kept", stat_upd, 5);
    chk("stats_mis_kept", stat_mispred, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
